// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse playback controller and its unit timer.
package morse_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        CHECK,
        MARK,
        SPACE,
        GAP,
        DONE
    } state_t;

    localparam logic [4:0] CODE_NONE   = 5'b10101;
    localparam logic [1:0] DOT_UNITS   = 2'd1;
    localparam logic [1:0] DASH_UNITS  = 2'd3;
    localparam logic [1:0] SPACE_UNITS = 2'd1;
    localparam logic [1:0] GAP_UNITS   = 2'd3;

    // Code bit 0 is a dot, 1 is a dash.
    function automatic logic [1:0] mark_units(input logic code_bit);
        return code_bit ? DASH_UNITS : DOT_UNITS;
    endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Loadable down-counter measuring a whole number of Morse units; expire is high
// in the last cycle of the loaded interval so the owner can reload on the same edge.
module morse_unit_timer #(
    parameter int UNIT_CYCLES = 12_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       load,
    input  logic [1:0] units,
    output logic       expire
);

    localparam int CW = $clog2(3 * UNIT_CYCLES);

    logic [CW-1:0] count_reg;
    logic          active_reg;
    logic [CW-1:0] load_value;

    // Loading N-1 makes an interval last exactly units*UNIT_CYCLES cycles.
    assign load_value = CW'(32'(units) * 32'(UNIT_CYCLES) - 32'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg  <= '0;
            active_reg <= 1'b0;
        end else if (clear) begin
            count_reg  <= '0;
            active_reg <= 1'b0;
        end else if (load) begin
            count_reg  <= load_value;
            active_reg <= 1'b1;
        end else if (active_reg) begin
            if (count_reg == '0) begin
                active_reg <= 1'b0;
            end else begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    assign expire = active_reg && (count_reg == '0);

endmodule

// File: rtl/morse_playback_ctrl.sv
// Scans display digits through an external encoder and keys each digit's Morse
// code onto tone, with unit-accurate mark, space and inter-digit gap timing.
module morse_playback_ctrl
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 12_500_000,
    parameter int NUM_DIGITS  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] digit_mask,
    input  logic [4:0] code_in,
    output logic [7:0] sel,
    output logic       tone,
    output logic       busy,
    output logic       done,
    output logic [2:0] digit_idx
);

    localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);

    state_t     state_reg, state_next;
    logic [2:0] digit_idx_reg, digit_idx_next;
    logic [2:0] bit_idx_reg, bit_idx_next;
    logic [4:0] code_reg, code_next;
    logic       sel_phase_reg, sel_phase_next;
    logic [7:0] sel_reg, sel_next;
    logic       tone_reg, tone_next;
    logic       busy_reg, busy_next;
    logic       done_reg, done_next;

    logic       timer_load;
    logic [1:0] timer_units;
    logic       timer_expire;
    logic       at_last;

    morse_unit_timer #(
        .UNIT_CYCLES(UNIT_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (abort),
        .load  (timer_load),
        .units (timer_units),
        .expire(timer_expire)
    );

    assign at_last = (digit_idx_reg == LAST_IDX);

    always_comb begin
        state_next     = state_reg;
        digit_idx_next = digit_idx_reg;
        bit_idx_next   = bit_idx_reg;
        code_next      = code_reg;
        sel_phase_next = 1'b0;
        timer_load     = 1'b0;
        timer_units    = 2'd0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    digit_idx_next = 3'd0;
                    state_next     = SEL;
                end
            end
            SEL: begin
                // Two select cycles give the encoder one cycle of registered latency.
                if (!sel_phase_reg) begin
                    sel_phase_next = 1'b1;
                end else begin
                    code_next  = code_in;
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (!digit_mask[digit_idx_reg] || code_reg == CODE_NONE) begin
                    if (at_last) begin
                        state_next = DONE;
                    end else begin
                        digit_idx_next = digit_idx_reg + 3'd1;
                        state_next     = SEL;
                    end
                end else begin
                    bit_idx_next = 3'd4;
                    state_next   = MARK;
                    timer_load   = 1'b1;
                    timer_units  = mark_units(code_reg[4]);
                end
            end
            MARK: begin
                if (timer_expire) begin
                    if (bit_idx_reg != 3'd0) begin
                        bit_idx_next = bit_idx_reg - 3'd1;
                        state_next   = SPACE;
                        timer_load   = 1'b1;
                        timer_units  = SPACE_UNITS;
                    end else if (!at_last) begin
                        state_next  = GAP;
                        timer_load  = 1'b1;
                        timer_units = GAP_UNITS;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            SPACE: begin
                if (timer_expire) begin
                    state_next  = MARK;
                    timer_load  = 1'b1;
                    timer_units = mark_units(code_reg[bit_idx_reg]);
                end
            end
            GAP: begin
                if (timer_expire) begin
                    if (at_last) begin
                        state_next = DONE;
                    end else begin
                        digit_idx_next = digit_idx_reg + 3'd1;
                        state_next     = SEL;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (abort) begin
            state_next     = IDLE;
            sel_phase_next = 1'b0;
            timer_load     = 1'b0;
        end

        // Outputs are decoded from the next state so they register alongside it.
        sel_next  = (state_next == SEL) ? (8'd1 << digit_idx_next) : 8'd0;
        tone_next = (state_next == MARK);
        busy_next = (state_next != IDLE);
        done_next = (state_next == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            digit_idx_reg <= 3'd0;
            bit_idx_reg   <= 3'd0;
            code_reg      <= CODE_NONE;
            sel_phase_reg <= 1'b0;
            sel_reg       <= 8'd0;
            tone_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            digit_idx_reg <= digit_idx_next;
            bit_idx_reg   <= bit_idx_next;
            code_reg      <= code_next;
            sel_phase_reg <= sel_phase_next;
            sel_reg       <= sel_next;
            tone_reg      <= tone_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    assign sel       = sel_reg;
    assign tone      = tone_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign digit_idx = digit_idx_reg;

endmodule

// File: doc/morse_playback_ctrl.md
MORSE_PLAYBACK_CTRL -- requirements
Module: morse_playback_ctrl

Interface
REQ-001 Parameter: UNIT_CYCLES, default 12_500_000, clk cycles per Morse time unit (minimum 2).
REQ-002 Parameter: NUM_DIGITS, default 8, number of display digits scanned.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle request to play all digits.
REQ-006 abort  input  1  stop playback immediately.
REQ-007 digit_mask  input  8  per-digit enable; 0 = skip digit.
REQ-008 code_in  input  5  per-digit Morse code from encoder; bit=0 dot, 1 dash, MSB sent first; 5'b10101 = none.
REQ-009 sel  output  8  one-hot digit select to encoder; 0 when idle.
REQ-010 tone  output  1  key/buzzer drive; 1 = mark.
REQ-011 busy  output  1  high from the cycle after start is accepted until the DONE cycle inclusive.
REQ-012 done  output  1  one-cycle pulse at end of a complete sequence.
REQ-013 digit_idx  output  3  index of digit currently selected.

Function
REQ-014 States: IDLE, SEL, CHECK, MARK, SPACE, GAP, DONE; all outputs registered.
REQ-015 IDLE: start=1 -> digit_idx=0, go SEL; start while busy ignored.
REQ-016 SEL: sel = 1<<digit_idx for exactly 2 cycles; code_in captured on the second cycle's edge (covers registered encoder latency).
REQ-017 CHECK: if digit_mask[digit_idx]=0 or captured code=5'b10101, advance digit with no tone and no gap; else bit_idx=4, go MARK.
REQ-018 MARK: tone=1 for 1 unit (bit=0) or 3 units (bit=1); unit = UNIT_CYCLES cycles.
REQ-019 After MARK with bit_idx>0: SPACE, tone=0 for 1 unit, bit_idx decrements, back to MARK.
REQ-020 After MARK with bit_idx=0: GAP (tone=0, 3 units) if digit_idx<NUM_DIGITS-1, else DONE.
REQ-021 Digit advance from CHECK/GAP: if digit_idx=NUM_DIGITS-1 go DONE (no wrap), else digit_idx+1, go SEL.
REQ-022 DONE: done=1, busy=1, sel=0 for one cycle, then IDLE.
REQ-023 abort (any state, priority over start and all transitions): next cycle IDLE, tone=0, sel=0, busy=0, no done pulse.
REQ-024 start and abort same cycle in IDLE: abort wins, stay IDLE.
REQ-025 Unit counter reloads on every state entry; mark/space lengths exact to the cycle (dot = UNIT_CYCLES, dash = 3*UNIT_CYCLES).
REQ-026 Captured code held constant for the whole digit; code_in changes outside SEL ignored.

Reset
REQ-027 rst=1 forces IDLE, sel=0, tone=0, busy=0, done=0, digit_idx=0, bit_idx=0, counters=0, captured code=5'b10101.
REQ-028 rst asserted mid-playback terminates it without done pulse; after release, block waits in IDLE for start.

Structure
REQ-029 Shared package morse_pkg: state enum, CODE_NONE=5'b10101, DOT_UNITS=1, DASH_UNITS=3, SPACE_UNITS=1, GAP_UNITS=3.
REQ-030 One sub-module morse_unit_timer: loadable down-counter of units x UNIT_CYCLES, outputs expire pulse.

Verification (UNIT_CYCLES=4, encoder model with 1-cycle latency)
REQ-031 Only digit0 enabled, code 5'b01111 ("1"): tone 4 on,4 off,12 on,4 off,12 on,4 off,12 on,4 off,12 on, then 12 off gap, done once; busy drops after done.
REQ-032 All digits code 5'b10101 -> tone never asserts, sel steps 0x01..0x80 two cycles each, done pulses.
REQ-033 digit_mask=8'h81, codes 5'b00000 ("5") -> five 4-cycle marks on digit0, gap, digits 1-6 skipped, five marks on digit7, done with no trailing gap.
REQ-034 abort during dash of digit3 -> next cycle tone=0, sel=0, busy=0, no done; new start replays from digit0.
REQ-035 start pulsed during playback -> ignored, sequence timing unchanged; rst mid-MARK -> all outputs at reset values immediately.
